axil_host_ctrl_regs: RTL and testbench

- AXI4-Lite responder (slave) register file; host driver programs host-bypass configuration through it.
- Holds the 64-bit host RAM base address and generates the init pulse consumed by the PCIe core initialiser.
- Reports initialiser completion back to software as a sticky status bit.
- Sits between the PCIe IP's AXI-Lite master (BAR0 window) and the init logic.

---
 rtl/axil_host_ctrl_pkg.sv | 39 +++
 rtl/axil_host_ctrl_regs.sv | 203 ++++++++++++++++++++
 tb/tb_axil_host_ctrl_regs.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_host_ctrl_pkg.sv
// rtl/axil_host_ctrl_pkg.sv - register map, field positions and response codes for the host control block
package axil_host_ctrl_pkg;

  localparam int ADDR_W    = 12;
  localparam int REG_IDX_W = ADDR_W - 2;

  // Register word indices (byte offset >> 2)
  localparam logic [REG_IDX_W-1:0] REG_ID          = 10'h000;
  localparam logic [REG_IDX_W-1:0] REG_CTRL        = 10'h001;
  localparam logic [REG_IDX_W-1:0] REG_STATUS      = 10'h002;
  localparam logic [REG_IDX_W-1:0] REG_RAM_BASE_LO = 10'h004;
  localparam logic [REG_IDX_W-1:0] REG_RAM_BASE_HI = 10'h005;
  localparam logic [REG_IDX_W-1:0] REG_SCRATCH     = 10'h006;

  localparam int CTRL_INIT_BIT    = 0;
  localparam int CTRL_ENABLE_BIT  = 1;
  localparam int STATUS_DONE_BIT  = 0;
  localparam int STATUS_BUSY_BIT  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic is_mapped(input logic [REG_IDX_W-1:0] idx);
    return (idx == REG_ID) || (idx == REG_CTRL) || (idx == REG_STATUS) ||
           (idx == REG_RAM_BASE_LO) || (idx == REG_RAM_BASE_HI) || (idx == REG_SCRATCH);
  endfunction

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_host_ctrl_regs.sv
// rtl/axil_host_ctrl_regs.sv - AXI4-Lite register file holding host RAM base, init pulse and done status
module axil_host_ctrl_regs
  import axil_host_ctrl_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'h4842_0001,
  parameter logic [63:0] RAM_BASE_RST = 64'h0,
  parameter logic [31:0] ERR_RDATA    = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i_n,
  input  logic [11:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [11:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready,
  output logic [63:0] ram_base_addr_o,
  output logic        init_o,
  input  logic        init_done_i,
  input  logic        busy_i
);

  logic                 aw_full_q, aw_full_d;
  logic [REG_IDX_W-1:0] aw_idx_q, aw_idx_d;
  logic                 w_full_q, w_full_d;
  logic [31:0]          w_data_q, w_data_d;
  logic [3:0]           w_strb_q, w_strb_d;
  logic                 awready_q, awready_d;
  logic                 wready_q, wready_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic                 arready_q, arready_d;
  logic                 rvalid_q, rvalid_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d;
  logic                 enable_q, enable_d;
  logic                 done_q, done_d;
  logic                 init_q, init_d;
  logic [31:0]          ram_lo_q, ram_lo_d;
  logic [31:0]          ram_hi_q, ram_hi_d;
  logic [31:0]          scratch_q, scratch_d;

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic [REG_IDX_W-1:0] ar_idx;
  logic [31:0]          rd_data;
  logic                 rd_ok;
  logic                 unused_addr_bits;

  assign aw_hs  = s_axil_awvalid && awready_q;
  assign w_hs   = s_axil_wvalid && wready_q;
  assign ar_hs  = s_axil_arvalid && arready_q;
  assign commit = aw_full_q && w_full_q;
  assign ar_idx = s_axil_araddr[11:2];
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  // Read mux sees register values before any same-cycle commit, so reads return old data
  always_comb begin
    rd_data = ERR_RDATA;
    rd_ok   = 1'b1;
    case (ar_idx)
      REG_ID:          rd_data = ID_VALUE;
      REG_CTRL:        rd_data = {30'b0, enable_q, 1'b0};
      REG_STATUS:      rd_data = {30'b0, busy_i, done_q};
      REG_RAM_BASE_LO: rd_data = ram_lo_q;
      REG_RAM_BASE_HI: rd_data = ram_hi_q;
      REG_SCRATCH:     rd_data = scratch_q;
      default:         rd_ok   = 1'b0;
    endcase
  end

  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    enable_d  = enable_q;
    done_d    = done_q;
    init_d    = 1'b0;
    ram_lo_d  = ram_lo_q;
    ram_hi_d  = ram_hi_q;
    scratch_d = scratch_q;

    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[11:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = s_axil_wdata;
      w_strb_d = s_axil_wstrb;
    end
    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      case (aw_idx_q)
        REG_CTRL: begin
          if (w_strb_q[0]) begin
            enable_d = w_data_q[CTRL_ENABLE_BIT];
            init_d   = w_data_q[CTRL_INIT_BIT] && enable_q;
          end
        end
        REG_STATUS: begin
          if (w_strb_q[0] && w_data_q[STATUS_DONE_BIT]) done_d = 1'b0;
        end
        REG_RAM_BASE_LO: ram_lo_d  = apply_wstrb(ram_lo_q, w_data_q, w_strb_q);
        REG_RAM_BASE_HI: ram_hi_d  = apply_wstrb(ram_hi_q, w_data_q, w_strb_q);
        REG_SCRATCH:     scratch_d = apply_wstrb(scratch_q, w_data_q, w_strb_q);
        default: ;
      endcase
    end

    // A completion pulse overrides a simultaneous software clear
    if (init_done_i) done_d = 1'b1;

    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;

    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    arready_d = !rvalid_d;
  end

  always_ff @(posedge clk_i or negedge rst_i_n) begin
    if (!rst_i_n) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      init_q    <= 1'b0;
      ram_lo_q  <= RAM_BASE_RST[31:0];
      ram_hi_q  <= RAM_BASE_RST[63:32];
      scratch_q <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      enable_q  <= enable_d;
      done_q    <= done_d;
      init_q    <= init_d;
      ram_lo_q  <= ram_lo_d;
      ram_hi_q  <= ram_hi_d;
      scratch_q <= scratch_d;
    end
  end

  assign s_axil_awready  = awready_q;
  assign s_axil_wready   = wready_q;
  assign s_axil_bvalid   = bvalid_q;
  assign s_axil_bresp    = bresp_q;
  assign s_axil_arready  = arready_q;
  assign s_axil_rvalid   = rvalid_q;
  assign s_axil_rdata    = rdata_q;
  assign s_axil_rresp    = rresp_q;
  assign ram_base_addr_o = {ram_hi_q, ram_lo_q};
  assign init_o          = init_q;

endmodule

// File: tb/tb_axil_host_ctrl_regs.sv
// tb/tb_axil_host_ctrl_regs.sv - self-checking bench for axil_host_ctrl_regs
module tb_axil_host_ctrl_regs;

  logic        clk_i = 1'b0;
  logic        rst_i_n;
  logic [11:0] s_axil_awaddr;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [11:0] s_axil_araddr;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;
  logic [63:0] ram_base_addr_o;
  logic        init_o;
  logic        init_done_i;
  logic        busy_i;

  always #5 clk_i = ~clk_i;

  axil_host_ctrl_regs dut (
    .clk_i(clk_i), .rst_i_n(rst_i_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .ram_base_addr_o(ram_base_addr_o), .init_o(init_o), .init_done_i(init_done_i), .busy_i(busy_i)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int hs_aw = 0;
  int hs_w = 0;
  int init_cycles = 0;
  int init_pulses = 0;
  logic init_prev = 1'b0;
  logic live = 1'b0;

  // Behavioural model of the software-visible state
  logic [31:0] m_lo = 32'h0, m_hi = 32'h0, m_scratch = 32'h0;
  logic        m_enable = 1'b0, m_done = 1'b0;
  int          m_init_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response, required one within the cycle bound", name);
  endtask

  function automatic logic [31:0] m_mask(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int idx;
    idx = int'(a >> 2);
    case (idx)
      0: return 32'h4842_0001;
      1: return {30'b0, m_enable, 1'b0};
      2: return {30'b0, busy_i, m_done};
      4: return m_lo;
      5: return m_hi;
      6: return m_scratch;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    case (idx)
      1: if (s[0]) begin
           if (d[0] && m_enable) m_init_count++;
           m_enable = d[1];
         end
      2: if (s[0] && d[0]) m_done = 1'b0;
      4: m_lo = m_mask(m_lo, d, s);
      5: m_hi = m_mask(m_hi, d, s);
      6: m_scratch = m_mask(m_scratch, d, s);
      default: ;
    endcase
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial forever begin
    @(posedge clk_i or negedge rst_i_n);
    live = rst_i_n;
  end

  initial forever begin
    @(negedge clk_i);
    if (init_o) begin
      init_cycles++;
      if (!init_prev) init_pulses++;
    end
    init_prev = init_o;
  end

  // Per-cycle compare against the model and the channel rules
  initial forever begin
    @(negedge clk_i);
    if (rst_i_n && live) begin
      chk("ram_base_addr", ram_base_addr_o, {m_hi, m_lo});
      chk("arready_is_not_rvalid", s_axil_arready, !s_axil_rvalid);
      if (s_axil_bvalid) begin
        chk("awready_low_during_b", s_axil_awready, 1'b0);
        chk("wready_low_during_b", s_axil_wready, 1'b0);
      end
    end
  end

  task automatic send_aw(input logic [11:0] a);
    s_axil_awaddr  = a;
    s_axil_awvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (s_axil_awready) begin
        @(posedge clk_i); #1;
        hs_aw = cyc;
        s_axil_awvalid = 1'b0;
        return;
      end
    end
    s_axil_awvalid = 1'b0;
    fail_timeout("aw_handshake");
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    s_axil_wdata  = d;
    s_axil_wstrb  = s;
    s_axil_wvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (s_axil_wready) begin
        @(posedge clk_i); #1;
        hs_w = cyc;
        s_axil_wvalid = 1'b0;
        return;
      end
    end
    s_axil_wvalid = 1'b0;
    fail_timeout("w_handshake");
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input int w_lead = 0, input int bhold = 0,
                          input logic collide = 1'b0);
    int later;
    if (bhold > 0) s_axil_bready = 1'b0;
    if (w_lead > 0) begin
      send_w(d, s);
      repeat (w_lead) begin
        @(posedge clk_i); #1;
        chk("wready_held_while_w_full", s_axil_wready, 1'b0);
      end
      send_aw(a);
    end else begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end
    later = (hs_aw > hs_w) ? hs_aw : hs_w;
    if (collide) init_done_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_axil_bvalid) break;
      @(posedge clk_i); #1;
      init_done_i = 1'b0;
    end
    if (!s_axil_bvalid) begin
      fail_timeout("bvalid");
      s_axil_bready = 1'b1;
      return;
    end
    chk("b_latency", cyc - later, 1);
    chk("bresp", s_axil_bresp, exp_resp);
    m_write(a, d, s);
    if (collide) m_done = 1'b1;
    repeat (bhold) begin
      @(negedge clk_i);
      chk("bvalid_held", s_axil_bvalid, 1'b1);
      chk("awready_low_b_held", s_axil_awready, 1'b0);
    end
    s_axil_bready = 1'b1;
    @(posedge clk_i); #1;
    chk("bvalid_drop", s_axil_bvalid, 1'b0);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [31:0] exp_data, input logic [1:0] exp_resp,
                         input int rhold = 0);
    logic [31:0] md;
    logic        ok;
    md = m_read(a);
    ok = 1'b0;
    if (rhold > 0) s_axil_rready = 1'b0;
    s_axil_araddr  = a;
    s_axil_arvalid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (s_axil_arready) begin
        @(posedge clk_i); #1;
        ok = 1'b1;
        break;
      end
    end
    s_axil_arvalid = 1'b0;
    if (!ok) begin
      fail_timeout("ar_handshake");
      s_axil_rready = 1'b1;
      return;
    end
    chk("rvalid_latency", s_axil_rvalid, 1'b1);
    chk("rdata_literal", s_axil_rdata, exp_data);
    chk("rdata_model", s_axil_rdata, md);
    chk("rresp", s_axil_rresp, exp_resp);
    repeat (rhold) begin
      @(negedge clk_i);
      chk("rvalid_held", s_axil_rvalid, 1'b1);
      chk("rdata_held", s_axil_rdata, exp_data);
    end
    s_axil_rready = 1'b1;
    @(posedge clk_i); #1;
    chk("rvalid_drop", s_axil_rvalid, 1'b0);
  endtask

  task automatic pulse_done();
    init_done_i = 1'b1;
    @(posedge clk_i); #1;
    init_done_i = 1'b0;
    m_done = 1'b1;
  endtask

  task automatic check_init(input int exp);
    repeat (3) @(posedge clk_i);
    #1;
    chk("init_pulses", init_pulses, exp);
    chk("init_high_cycles", init_cycles, exp);
    chk("init_model", init_pulses, m_init_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    rst_i_n = 1'b0;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b1;
    init_done_i = 1'b0;
    busy_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_awready", s_axil_awready, 1'b0);
    chk("rst_wready", s_axil_wready, 1'b0);
    chk("rst_arready", s_axil_arready, 1'b0);
    chk("rst_bvalid", s_axil_bvalid, 1'b0);
    chk("rst_rvalid", s_axil_rvalid, 1'b0);
    chk("rst_rdata", s_axil_rdata, 32'h0);
    chk("rst_resps", {s_axil_bresp, s_axil_rresp}, 4'b0000);
    chk("rst_init", init_o, 1'b0);
    chk("rst_ram_base", ram_base_addr_o, 64'h0);
    #2 rst_i_n = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_release", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // RAM base programming
    do_write(12'h010, 32'hCAFE_0000, 4'hF, 2'b00);
    do_write(12'h014, 32'h0000_00BA, 4'hF, 2'b00);
    chk("ram_base_literal", ram_base_addr_o, 64'h0000_00BA_CAFE_0000);

    // W ahead of AW with partial strobes
    do_write(12'h018, 32'h1234_5678, 4'b0101, 2'b00, 3);
    do_read(12'h018, 32'h0034_0078, 2'b00);

    // INIT gated by ENABLE
    do_write(12'h004, 32'h1, 4'hF, 2'b00);
    check_init(0);
    do_write(12'h004, 32'h2, 4'hF, 2'b00);
    check_init(0);
    do_write(12'h004, 32'h3, 4'hF, 2'b00);
    check_init(1);
    do_read(12'h004, 32'h2, 2'b00);

    // DONE sticky, W1C, set wins over clear, live BUSY
    pulse_done();
    do_read(12'h008, 32'h1, 2'b00);
    do_write(12'h008, 32'h1, 4'hF, 2'b00);
    do_read(12'h008, 32'h0, 2'b00);
    do_write(12'h008, 32'h1, 4'hF, 2'b00, 0, 0, 1'b1);
    do_read(12'h008, 32'h1, 2'b00);
    busy_i = 1'b1;
    do_read(12'h008, 32'h3, 2'b00);
    busy_i = 1'b0;

    // ID, unmapped, RO writes, backpressure
    do_read(12'h000, 32'h4842_0001, 2'b00);
    do_read(12'h0FC, 32'hDEAD_BEEF, 2'b10, 5);
    do_read(12'h00C, 32'hDEAD_BEEF, 2'b10);
    do_write(12'h0FC, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 5);
    do_read(12'h018, 32'h0034_0078, 2'b00);
    do_write(12'h000, 32'h0, 4'hF, 2'b00);
    do_read(12'h000, 32'h4842_0001, 2'b00);
    do_write(12'h010, 32'hFFFF_FFFF, 4'b1000, 2'b00);
    do_read(12'h013, 32'hFFFE_0000, 2'b00);
    check_init(1);

    // Reset with bvalid pending and a new AW/W held off
    s_axil_bready = 1'b0;
    fork
      send_aw(12'h018);
      send_w(32'hAAAA_5555, 4'hF);
    join
    for (int i = 0; i < 20; i++) begin
      if (s_axil_bvalid) break;
      @(posedge clk_i); #1;
    end
    chk("pending_bvalid", s_axil_bvalid, 1'b1);
    s_axil_awaddr = 12'h004; s_axil_awvalid = 1'b1;
    s_axil_wdata = 32'h3; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(posedge clk_i); #1;
    chk("aw_held_off", s_axil_awready, 1'b0);
    #2 rst_i_n = 1'b0;
    m_lo = 32'h0; m_hi = 32'h0; m_scratch = 32'h0; m_enable = 1'b0; m_done = 1'b0;
    #1;
    chk("async_rst_bvalid", s_axil_bvalid, 1'b0);
    chk("async_rst_readys", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b000);
    chk("async_rst_ram_base", ram_base_addr_o, 64'h0);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
    repeat (2) @(posedge clk_i);
    #3 rst_i_n = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_second_release", s_axil_awready, 1'b1);
    check_init(1);
    do_read(12'h010, 32'h0, 2'b00);
    do_read(12'h004, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
